divisor: RTL and testbench
==========================

Name: divisor

Overview:
- Sequential signed 32-bit divider for the multicycle MIPS datapath; implements DIV.
- Takes operands from the A and B registers. Produces quotient (LO) and remainder (HI), which feed the high/low source muxes ahead of the HIGH/LOW registers.
- Handshakes with the control unit: start pulse in; done and divide-by-zero indications out.
- Uses restoring division, one quotient bit per clock.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is required to be verified.

Ports:
- clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- A  input  WIDTH  dividend, two's complement.
- B  input  WIDTH  divisor, two's complement.
- DivIn  input  1  start request, sampled on rising edge of clk.
- resultHigh  output  WIDTH  remainder, registered.
- resultLow  output  WIDTH  quotient, registered.
- DivOut  output  1  done pulse, registered.
- DivZero  output  1  divide-by-zero pulse, registered.

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE; counter, internal remainder, quotient and divisor registers = 0; resultHigh=0, resultLow=0, DivOut=0, DivZero=0. Reset asserted mid-operation aborts the divide immediately; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE, DivIn=1 at edge E0:
  - If B==0: DivZero=1 for exactly one cycle (E0 to E1). resultHigh/resultLow unchanged. Stay IDLE.
  - Else: latch |A| and |B| as WIDTH-bit unsigned magnitudes. Latch sign_q = A[31]^B[31] and sign_r = A[31]. Clear partial remainder. counter=WIDTH. Go to RUN.
- RUN, each edge:
  - rem = {rem[30:0], dvd[31]}; dvd shifts left by 1.
  - If rem >= |B|: rem -= |B| and shift 1 into the quotient LSB; else shift 0.
  - Subtraction is performed in WIDTH+1 bits so a magnitude of 0x80000000 is handled without overflow.
  - counter decrements; after the WIDTH-th iteration (edge E32), go to DONE.
- DONE (edge E33):
  - resultLow = sign_q ? -q : q.
  - resultHigh = sign_r ? -rem : rem.
  - DivOut=1 for exactly the cycle E33 to E34; return to IDLE at E34.
- Latency: DivOut is high 33 cycles after the start edge; the divider is busy from E0 to E34.
- Semantics:
  - Quotient truncates toward zero; remainder takes the sign of the dividend; A = Q*B + R always holds.
  - 0x80000000 / 0xFFFFFFFF gives Q=0x80000000, R=0, with no flag.
- DivIn asserted while in RUN or DONE is ignored (not queued).
- A and B changes after E0 do not affect the operation in progress.
- DivIn held high continuously re-triggers on the first IDLE edge after completion.
- DivOut and DivZero are never high in the same cycle, and each is a single-cycle pulse.
- resultHigh/resultLow hold their last value except at a DONE edge or reset.
- Timing: no combinational path from any input to any output.

Test Plan:
- A=7, B=2, DivIn pulse -> DivOut high exactly 33 cycles later; resultLow=3, resultHigh=1.
- A=-7 (0xFFFFFFF9), B=2 -> resultLow=0xFFFFFFFD, resultHigh=0xFFFFFFFF. A=7, B=-2 -> resultLow=0xFFFFFFFD, resultHigh=1.
- After a 7/2 run, A=100, B=0, DivIn -> DivZero high one cycle after the start edge; DivOut never asserts; results stay 3/1.
- A=0x80000000, B=0xFFFFFFFF -> resultLow=0x80000000, resultHigh=0. A=0x80000000, B=1 -> resultLow=0x80000000, resultHigh=0.
- Start 1000/7, pulse DivIn again and change A/B at cycle 10 -> single DivOut at cycle 33 with resultLow=142, resultHigh=6.
- Start 1000/7, assert Reset low at cycle 15 -> all outputs 0 immediately. After release, start 9/3 -> resultLow=3, resultHigh=0, with normal latency.

Source files
------------

// File: rtl/divisor.sv
// divisor: sequential signed divider (DIV) for the multicycle MIPS datapath.
// Restoring division on operand magnitudes, one quotient bit per clock.
// The signs are applied to the quotient and remainder at the end.
// Quotient goes to resultLow (LO) and remainder to resultHigh (HI).
module divisor #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             DivIn,
    output logic [WIDTH-1:0] resultHigh,
    output logic [WIDTH-1:0] resultLow,
    output logic             DivOut,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_sign_q;
    logic             r_sign_r;

    logic             w_start;
    logic             w_zero;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;

    // Two's complement magnitude; 0x80000000 maps to itself as an unsigned value.
    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? ((~v) + WIDTH'(1)) : v;
    endfunction

    // Re-apply a sign to an unsigned magnitude.
    function automatic logic [WIDTH-1:0] f_apply_sign(input logic [WIDTH-1:0] mag,
                                                      input logic             neg);
        return neg ? ((~mag) + WIDTH'(1)) : mag;
    endfunction

    assign w_start = (r_state == S_IDLE) && DivIn && (B != '0);
    assign w_zero  = (r_state == S_IDLE) && DivIn && (B == '0);

    // One restoring step. The subtraction is one bit wider than the operands,
    // so a divisor magnitude of 0x80000000 cannot overflow it. The borrow
    // (top bit of w_diff) shows that the shifted remainder was smaller.
    assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_ge      = ~w_diff[WIDTH];
    assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

    // State register
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic. DONE lasts two cycles: the first writes the results,
    // and the second holds the done pulse before the FSM returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_state_nxt = S_RUN;
            S_RUN:  if (r_cnt == CW'(1)) w_state_nxt = S_DONE;
            S_DONE: if (DivOut) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, result write-back and status pulses
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_dvd      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            resultHigh <= '0;
            resultLow  <= '0;
            DivOut     <= 1'b0;
            DivZero    <= 1'b0;
        end else begin
            DivOut  <= 1'b0;
            DivZero <= w_zero;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_dvd    <= f_abs(A);
                        r_dvs    <= f_abs(B);
                        r_sign_q <= A[WIDTH-1] ^ B[WIDTH-1];
                        r_sign_r <= A[WIDTH-1];
                        r_rem    <= '0;
                        r_quo    <= '0;
                        r_cnt    <= CW'(WIDTH);
                    end
                end
                S_RUN: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt - CW'(1);
                end
                S_DONE: begin
                    if (!DivOut) begin
                        resultLow  <= f_apply_sign(r_quo, r_sign_q);
                        resultHigh <= f_apply_sign(r_rem, r_sign_r);
                        DivOut     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divisor.sv
// tb_divisor: directed checks of the signed sequential divider.
module tb_divisor;

    logic        clk;
    logic        Reset;
    logic [31:0] A;
    logic [31:0] B;
    logic        DivIn;
    logic [31:0] resultHigh;
    logic [31:0] resultLow;
    logic        DivOut;
    logic        DivZero;

    int n_asserts = 0;
    int n_fail    = 0;
    int n;

    divisor #(.WIDTH(32)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .A          (A),
        .B          (B),
        .DivIn      (DivIn),
        .resultHigh (resultHigh),
        .resultLow  (resultLow),
        .DivOut     (DivOut),
        .DivZero    (DivZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle start pulse; returns just after the start edge E0.
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        A     = a;
        B     = b;
        DivIn = 1'b1;
        @(posedge clk);
        #1;
        DivIn = 1'b0;
    endtask

    // Count edges after E0 until DivOut is seen (bounded).
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (DivOut !== 1'b1 && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    // Observe a window in which DivOut must stay low.
    task automatic quiet(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (DivOut !== 1'b0) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd0);
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_q, input logic [31:0] exp_r);
        int cyc;
        start(a, b);
        wait_done(cyc);
        chk({tag, "_latency"}, cyc, 32'd33);
        chk({tag, "_lo"}, resultLow, exp_q);
        chk({tag, "_hi"}, resultHigh, exp_r);
        @(posedge clk);
        #1;
        chk({tag, "_doneoff"}, {31'd0, DivOut}, 32'd0);
    endtask

    initial begin
        A     = '0;
        B     = '0;
        DivIn = 1'b0;
        Reset = 1'b1;
        #2 Reset = 1'b0;
        #1;
        chk("rst_hi",   resultHigh, 32'd0);
        chk("rst_lo",   resultLow,  32'd0);
        chk("rst_done", {31'd0, DivOut},  32'd0);
        chk("rst_zero", {31'd0, DivZero}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        Reset = 1'b1;

        // Basic positive divide with latency check
        run_div("d7_2", 32'd7, 32'd2, 32'd3, 32'd1);

        // Divide by zero: pulse only, results untouched
        start(32'd100, 32'd0);
        chk("dz_pulse", {31'd0, DivZero}, 32'd1);
        chk("dz_nodone", {31'd0, DivOut}, 32'd0);
        @(posedge clk);
        #1;
        chk("dz_off", {31'd0, DivZero}, 32'd0);
        quiet("dz_quiet", 40);
        chk("dz_lo", resultLow,  32'd3);
        chk("dz_hi", resultHigh, 32'd1);

        // Signed cases
        run_div("dm7_2", 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("d7_m2", 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run_div("dmin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_div("dmin_1",  32'h8000_0000, 32'd1,         32'h8000_0000, 32'd0);
        run_div("dm100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE);

        // Re-request and operand changes mid-run must be ignored
        start(32'd1000, 32'd7);
        n = 0;
        while (DivOut !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 10) begin
                DivIn = 1'b1;
                A     = 32'd5;
                B     = 32'd1;
            end else begin
                DivIn = 1'b0;
            end
        end
        chk("ign_latency", n, 32'd33);
        chk("ign_lo", resultLow,  32'd142);
        chk("ign_hi", resultHigh, 32'd6);
        quiet("ign_single", 40);

        // Asynchronous reset in the middle of a divide
        start(32'd1000, 32'd7);
        repeat (15) @(posedge clk);
        #1;
        Reset = 1'b0;
        #1;
        chk("mrst_hi",   resultHigh, 32'd0);
        chk("mrst_lo",   resultLow,  32'd0);
        chk("mrst_done", {31'd0, DivOut},  32'd0);
        chk("mrst_zero", {31'd0, DivZero}, 32'd0);
        @(negedge clk);
        Reset = 1'b1;
        quiet("mrst_abort", 40);

        run_div("d9_3", 32'd9, 32'd3, 32'd3, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
